// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, start-bit validation at half a bit,
// mid-bit data sampling, stop-bit check, and a level/ack handshake with overrun.
module uart_rx #(
  parameter int unsigned BITS         = 8,
  parameter int unsigned CLKS_PER_BIT = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            data_ack,
  output logic [BITS-1:0] data,
  output logic            data_ready,
  output logic            frame_err,
  output logic            overrun
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(BITS - 1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_START = 5'b00010,
    S_DATA  = 5'b00100,
    S_STOP  = 5'b01000,
    S_BREAK = 5'b10000
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              rx_s_q, rx_s_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BITS-1:0]   shift_q, shift_d;
  logic [BITS-1:0]   data_q, data_d;
  logic              ready_q, ready_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  // Next-state logic: synchronizer, frame sequencing and consumer handshake
  always_comb begin
    sync1_d = rx;
    rx_s_d  = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    // Ack only has an effect while a word is pending
    if (data_ack && ready_q) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          // A line that is high again at mid start bit was a glitch
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting right lands it in bit 0
          shift_d = {rx_s_q, shift_q[BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            // A completion coinciding with ack is not an overrun
            ovr_d   = ovr_d | (ready_q & ~data_ack);
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        // Hold off until the line returns high so a break is not read as starts
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      rx_s_q  <= rx_s_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data       = data_q;
  assign data_ready = ready_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
